// File: rtl/rv_alu_pkg.sv
// rv_alu_pkg: shared RV32 ALU-side constants.
//   - ALU function-select (GS) codes consumed by the execute ALU
//   - Opcode and funct3 encodings for the integer ALU instruction groups
//   - alu_op_t: one decoded ALU operation as held in the decode stage register
package rv_alu_pkg;

   typedef enum logic [3:0] {
      GS_ADD  = 4'b0000,
      GS_SUB  = 4'b1000,
      GS_SLT  = 4'b0010,
      GS_SLTU = 4'b0011,
      GS_AND  = 4'b0100,
      GS_OR   = 4'b0101,
      GS_XOR  = 4'b0110
   } alu_gs_e;

   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  gs;
      logic [4:0]  rd;
      logic        wb_en;
      logic        illegal;
   } alu_op_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: purely combinational RV32 integer-ALU decoder.
// Ports:
//   instr, pc, rs1_data, rs2_data  in  instruction word, its address, register operands
//   A, B                           out ALU operands
//   GS                             out ALU function select
//   rd                             out destination register (always instr[11:7])
//   wb_en                          out write-back enable (legal and rd != x0)
//   illegal                        out instruction not supported by this ALU path
// Shift encodings decode as illegal.
module alu_ctrl_dec
   import rv_alu_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic [31:0] A,
   output logic [31:0] B,
   output logic [3:0]  GS,
   output logic [4:0]  rd,
   output logic        wb_en,
   output logic        illegal
);

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_u;
   logic [3:0]  w_f3_gs;
   logic        w_f3_ok;

   assign w_opcode = instr[6:0];
   assign w_funct3 = instr[14:12];
   assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign w_imm_u  = {instr[31:12], 12'h000};

   // funct3 -> GS mapping shared by register and immediate forms
   always_comb begin
      w_f3_ok = 1'b1;
      w_f3_gs = GS_ADD;
      case (w_funct3)
         F3_ADD:  w_f3_gs = GS_ADD;
         F3_SLT:  w_f3_gs = GS_SLT;
         F3_SLTU: w_f3_gs = GS_SLTU;
         F3_XOR:  w_f3_gs = GS_XOR;
         F3_OR:   w_f3_gs = GS_OR;
         F3_AND:  w_f3_gs = GS_AND;
         default: w_f3_ok = 1'b0;   // SLL / SRL / SRA
      endcase
   end

   always_comb begin
      A       = '0;
      B       = '0;
      GS      = GS_ADD;
      illegal = 1'b1;
      case (w_opcode)
         OP_REG: if (w_f3_ok) begin
            A       = rs1_data;
            B       = rs2_data;
            // only funct7[5] distinguishes SUB; other funct7 bits are ignored
            GS      = (w_funct3 == F3_ADD && instr[30]) ? GS_SUB : w_f3_gs;
            illegal = 1'b0;
         end
         OP_IMM: if (w_f3_ok) begin
            A       = rs1_data;
            B       = w_imm_i;
            GS      = w_f3_gs;
            illegal = 1'b0;
         end
         OP_LUI: begin
            B       = w_imm_u;
            illegal = 1'b0;
         end
         OP_AUIPC: begin
            A       = pc;
            B       = w_imm_u;
            illegal = 1'b0;
         end
         default: ;
      endcase
   end

   assign rd    = instr[11:7];
   assign wb_en = ~illegal & (|instr[11:7]);

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: single-entry registered decode stage feeding the ALU.
// Ports:
//   clk, rst                          clock (rising edge), async active-high reset
//   in_valid/in_ready                 upstream handshake; in_ready is combinational
//   instr, pc, rs1_data, rs2_data     instruction and its operands
//   flush                             kill held entry and drop this cycle's input
//   out_valid/out_ready               downstream handshake
//   A, B, GS, rd, wb_en, illegal      registered decoded ALU operation
//   illegal_cnt                       saturating count of illegal instructions loaded
// Decode itself lives in alu_ctrl_dec; this level holds only the entry register,
// handshake and counter. Data outputs hold their last value when out_valid drops.
module alu_decode_stage
   import rv_alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] A,
   output logic [31:0] B,
   output logic [3:0]  GS,
   output logic [4:0]  rd,
   output logic        wb_en,
   output logic        illegal,
   output logic [15:0] illegal_cnt
);

   alu_op_t     w_dec;
   alu_op_t     r_op;
   logic        r_valid;
   logic [15:0] r_illegal_cnt;
   logic        w_load;

   alu_ctrl_dec u_dec (
      .instr    (instr),
      .pc       (pc),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .A        (w_dec.a),
      .B        (w_dec.b),
      .GS       (w_dec.gs),
      .rd       (w_dec.rd),
      .wb_en    (w_dec.wb_en),
      .illegal  (w_dec.illegal)
   );

   // entry is free when empty or being drained this cycle
   assign in_ready = ~r_valid | out_ready;
   assign w_load   = in_valid & in_ready & ~flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid       <= 1'b0;
         r_op          <= '{a: '0, b: '0, gs: GS_ADD, rd: '0, wb_en: 1'b0, illegal: 1'b0};
         r_illegal_cnt <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_op    <= w_dec;
         if (w_dec.illegal && r_illegal_cnt != 16'hFFFF)
            r_illegal_cnt <= r_illegal_cnt + 16'd1;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid   = r_valid;
   assign A           = r_op.a;
   assign B           = r_op.b;
   assign GS          = r_op.gs;
   assign rd          = r_op.rd;
   assign wb_en       = r_op.wb_en;
   assign illegal     = r_op.illegal;
   assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_alu_decode_stage.sv
module tb_alu_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] instr, pc, rs1_data, rs2_data, A, B;
   logic [3:0]  GS;
   logic [4:0]  rd;
   logic        wb_en, illegal;
   logic [15:0] illegal_cnt;

   int n_chk = 0;
   int n_fail = 0;

   // reference state: what the stage should be presenting
   logic        e_v;
   logic [31:0] e_a, e_b;
   logic [3:0]  e_gs;
   logic [4:0]  e_rd;
   logic        e_wb, e_ill;
   logic [15:0] e_cnt;

   always #5 clk = ~clk;

   alu_decode_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .A(A), .B(B), .GS(GS), .rd(rd), .wb_en(wb_en), .illegal(illegal),
      .illegal_cnt(illegal_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Decode from the ISA rules: classify the instruction, then pick operands.
   function automatic void ref_dec(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   output logic [31:0] a, output logic [31:0] b,
                                   output logic [3:0] gs, output logic [4:0] rdv,
                                   output logic wb, output logic ill);
      logic [6:0] op;
      logic [2:0] f3;
      bit         legal;
      int         imm;
      op = ins[6:0];
      f3 = ins[14:12];
      legal = 0;
      a = 0; b = 0; gs = 4'b0000;
      imm = $signed(ins[31:20]);
      if ((op == 7'h33 || op == 7'h13) && f3 != 3'd1 && f3 != 3'd5) begin
         legal = 1;
         a = r1;
         b = (op == 7'h33) ? r2 : imm;
         case (f3)
            3'd0: gs = (op == 7'h33 && ins[30]) ? 4'b1000 : 4'b0000;
            3'd2: gs = 4'b0010;
            3'd3: gs = 4'b0011;
            3'd4: gs = 4'b0110;
            3'd6: gs = 4'b0101;
            default: gs = 4'b0100;
         endcase
      end else if (op == 7'h37) begin
         legal = 1;
         b = ins & 32'hFFFF_F000;
      end else if (op == 7'h17) begin
         legal = 1;
         a = p;
         b = ins & 32'hFFFF_F000;
      end
      rdv = ins[11:7];
      ill = !legal;
      wb  = legal && (rdv != 5'd0);
   endfunction

   task automatic model_reset();
      e_v = 0; e_a = 0; e_b = 0; e_gs = 0; e_rd = 0; e_wb = 0; e_ill = 0; e_cnt = 0;
   endtask

   task automatic chk_outs(input string tag);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_v));
      chk({tag, ".A"}, A, e_a);
      chk({tag, ".B"}, B, e_b);
      chk({tag, ".GS"}, 32'(GS), 32'(e_gs));
      chk({tag, ".rd"}, 32'(rd), 32'(e_rd));
      chk({tag, ".wb_en"}, 32'(wb_en), 32'(e_wb));
      chk({tag, ".illegal"}, 32'(illegal), 32'(e_ill));
      chk({tag, ".cnt"}, 32'(illegal_cnt), 32'(e_cnt));
   endtask

   // One cycle: drive at negedge, check in_ready, step the model across the edge,
   // check the registered outputs at the next negedge.
   task automatic cyc(input string tag, input logic iv, input logic ordy, input logic fl,
                      input logic [31:0] ins, input logic [31:0] p,
                      input logic [31:0] r1, input logic [31:0] r2);
      logic        rdy;
      logic [31:0] a, b;
      logic [3:0]  gs;
      logic [4:0]  rdv;
      logic        wb, ill;
      in_valid = iv; out_ready = ordy; flush = fl;
      instr = ins; pc = p; rs1_data = r1; rs2_data = r2;
      rdy = !e_v || ordy;
      #1 chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
      @(posedge clk);
      if (fl) e_v = 0;
      else if (iv && rdy) begin
         ref_dec(ins, p, r1, r2, a, b, gs, rdv, wb, ill);
         e_v = 1; e_a = a; e_b = b; e_gs = gs; e_rd = rdv; e_wb = wb; e_ill = ill;
         if (ill && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
      end else if (ordy) e_v = 0;
      @(negedge clk);
      chk_outs(tag);
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [31:0] ins;
      ins = $urandom;
      case ($urandom_range(0, 5))
         0, 1: ins[6:0] = 7'b0110011;
         2:    ins[6:0] = 7'b0010011;
         3:    ins[6:0] = 7'b0110111;
         4:    ins[6:0] = 7'b0010111;
         default: ;
      endcase
      case ($urandom_range(0, 2))
         0: ins[31:25] = 7'h00;
         1: ins[31:25] = 7'h20;
         default: ;
      endcase
      return ins;
   endfunction

   initial begin
      rst = 1; in_valid = 0; out_ready = 0; flush = 0;
      instr = 0; pc = 0; rs1_data = 0; rs2_data = 0;
      model_reset();
      #2;
      chk_outs("reset");
      chk("reset.in_ready", 32'(in_ready), 32'd1);
      @(negedge clk); @(negedge clk);
      rst = 0;

      // basic ADD / SUB / ADDI
      cyc("add", 1, 1, 0, 32'h002081B3, 32'h100, 5, 7);
      chk("add.A_lit", A, 32'd5);
      chk("add.B_lit", B, 32'd7);
      chk("add.rd_lit", 32'(rd), 32'd3);
      cyc("sub", 1, 1, 0, 32'h402081B3, 32'h104, 9, 4);
      chk("sub.GS_lit", 32'(GS), 32'h8);
      cyc("addi", 1, 1, 0, 32'hFFF00293, 32'h108, 32'h1234, 0);
      chk("addi.B_lit", B, 32'hFFFF_FFFF);
      cyc("lui", 1, 1, 0, 32'hABCDE0B7, 32'h10C, 1, 2);
      cyc("auipc", 1, 1, 0, 32'h00001117, 32'h110, 1, 2);
      cyc("idle", 0, 1, 0, 32'h0, 0, 0, 0);

      // stall: held entry must not move, next instr waits for out_ready
      cyc("st0", 1, 0, 0, 32'h0020F1B3, 32'h200, 32'hF0F0, 32'h0FF0);
      for (int i = 0; i < 3; i++)
         cyc("stall", 1, 0, 0, 32'h0020E233, 32'h204, 11, 22);
      chk("stall.A_held", A, 32'hF0F0);
      cyc("unstall", 1, 1, 0, 32'h0020E233, 32'h204, 11, 22);
      chk("unstall.GS", 32'(GS), 32'h5);

      // shift is illegal and counts
      cyc("shift", 1, 1, 0, 32'h00209093, 32'h300, 3, 4);
      chk("shift.cnt_lit", 32'(illegal_cnt), 32'd1);

      // flush beats a valid input, counter unchanged
      cyc("fl0", 1, 0, 0, 32'h002081B3, 32'h400, 1, 1);
      cyc("flush", 1, 0, 1, 32'h00209093, 32'h404, 1, 1);
      chk("flush.cnt_lit", 32'(illegal_cnt), 32'd1);

      // reset in the middle of a stall
      cyc("rs0", 1, 0, 0, 32'h002081B3, 32'h500, 1, 1);
      cyc("rs1", 1, 0, 0, 32'h00209093, 32'h504, 1, 1);
      #2 rst = 1;
      #1 model_reset();
      chk_outs("rst_async");
      chk("rst_async.in_ready", 32'(in_ready), 32'd1);
      in_valid = 0;
      @(negedge clk); rst = 0;
      cyc("post_rst", 0, 1, 0, 32'h0, 0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 2000; i++)
         cyc("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
             ($urandom_range(0, 15) == 0), rnd_instr(), $urandom, $urandom, $urandom);

      // drive the counter to saturation
      for (int i = 0; i < 70000 && e_cnt != 16'hFFFF; i++)
         cyc("burst", 1, 1, 0, 32'h00209093, 0, 0, 0);
      chk("sat.reach", 32'(illegal_cnt), 32'hFFFF);
      for (int i = 0; i < 3; i++)
         cyc("sat", 1, 1, 0, 32'h0020D093, 0, 0, 0);
      chk("sat.hold", 32'(illegal_cnt), 32'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
